// File: rtl/input_request_controller.sv
// Input-instruction handshake: stalls the CPU, raises FLAG_input, captures the
// switch word on confirm and issues a single register-file write.
module input_request_controller #(
    parameter int SIGN_EXTEND = 0,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_req,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic [15:0]       FPGA_input,
    input  logic              FPGA_input_confirm,
    output logic              FLAG_input,
    output logic              cpu_stall,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic              input_waiting
);

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WAIT_CONFIRM = 3'd1,
        ST_WRITEBACK    = 3'd2,
        ST_RELEASE      = 3'd3,
        ST_DONE         = 3'd4
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic              flag_r;
    logic              rf_write_r;
    logic [ADDR_W-1:0] rf_waddr_r;
    logic [31:0]       rf_wdata_r;
    logic              cpu_stall_s;

    function automatic logic [31:0] extend_word(input logic [15:0] word);
        if (SIGN_EXTEND != 0) begin
            return {{16{word[15]}}, word};
        end else begin
            return {16'h0000, word};
        end
    endfunction

    // Next-state logic; an accepted request always runs to DONE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_req) begin
                    next_state_s = ST_WAIT_CONFIRM;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT_CONFIRM: begin
                if (FPGA_input_confirm) begin
                    next_state_s = ST_WRITEBACK;
                end else begin
                    next_state_s = ST_WAIT_CONFIRM;
                end
            end
            ST_WRITEBACK: begin
                next_state_s = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (FPGA_input_confirm) begin
                    next_state_s = ST_RELEASE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Stall covers the request cycle itself so the PC holds on the input instruction.
    always_comb begin
        cpu_stall_s = 1'b0;
        case (state_r)
            ST_IDLE:         cpu_stall_s = in_req;
            ST_WAIT_CONFIRM: cpu_stall_s = 1'b1;
            ST_WRITEBACK:    cpu_stall_s = 1'b1;
            ST_RELEASE:      cpu_stall_s = 1'b1;
            ST_DONE:         cpu_stall_s = 1'b0;
            default:         cpu_stall_s = 1'b0;
        endcase
    end

    // State register and registered outputs, decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            flag_r     <= 1'b0;
            rf_write_r <= 1'b0;
            rf_waddr_r <= '0;
            rf_wdata_r <= 32'h0000_0000;
        end else begin
            state_r    <= next_state_s;
            flag_r     <= (next_state_s == ST_WAIT_CONFIRM);
            rf_write_r <= (next_state_s == ST_WRITEBACK);
            if ((state_r == ST_IDLE) && in_req) begin
                rf_waddr_r <= in_dest;
            end else begin
                rf_waddr_r <= rf_waddr_r;
            end
            if ((state_r == ST_WAIT_CONFIRM) && FPGA_input_confirm) begin
                rf_wdata_r <= extend_word(FPGA_input);
            end else begin
                rf_wdata_r <= rf_wdata_r;
            end
        end
    end

    assign FLAG_input    = flag_r;
    assign input_waiting = flag_r;
    assign rf_write      = rf_write_r;
    assign rf_waddr      = rf_waddr_r;
    assign rf_wdata      = rf_wdata_r;
    assign cpu_stall     = cpu_stall_s;

endmodule

// File: tb/tb_input_request_controller.sv
// Directed bench: zero-extend (u0) and sign-extend (u1) instances share stimulus.
module tb_input_request_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_req;
    logic [4:0]  in_dest;
    logic [15:0] fpga_in;
    logic        confirm;

    logic        flag0, stall0, wr0, wait0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        flag1, stall1, wr1, wait1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int rise_cnt = 0;
    logic flag_prev = 1'b0;

    always #5 clk = ~clk;

    input_request_controller #(.SIGN_EXTEND(0), .ADDR_W(5)) u0 (
        .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_dest(in_dest),
        .FPGA_input(fpga_in), .FPGA_input_confirm(confirm),
        .FLAG_input(flag0), .cpu_stall(stall0), .rf_write(wr0),
        .rf_waddr(waddr0), .rf_wdata(wdata0), .input_waiting(wait0));

    input_request_controller #(.SIGN_EXTEND(1), .ADDR_W(5)) u1 (
        .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_dest(in_dest),
        .FPGA_input(fpga_in), .FPGA_input_confirm(confirm),
        .FLAG_input(flag1), .cpu_stall(stall1), .rf_write(wr1),
        .rf_waddr(waddr1), .rf_wdata(wdata1), .input_waiting(wait1));

    // Count write pulses and flag rising edges seen at clock edges
    always @(posedge clk) begin
        if (wr0) wr_cnt <= wr_cnt + 1;
        if (flag0 && !flag_prev) rise_cnt <= rise_cnt + 1;
        flag_prev <= flag0;
    end

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_req = 1'b0; in_dest = 5'd0; fpga_in = 16'h0000; confirm = 1'b0;
        step(); step();
        checks++; if (flag0 !== 1'b0 || wait0 !== 1'b0) begin failures++; $display("FAIL reset_flag flag=%b wait=%b exp 0", flag0, wait0); end
        checks++; if (wr0 !== 1'b0 || waddr0 !== 5'd0 || wdata0 !== 32'h0) begin failures++; $display("FAIL reset_rf wr=%b addr=%0d data=%h exp 0", wr0, waddr0, wdata0); end
        checks++; if (stall0 !== 1'b0) begin failures++; $display("FAIL reset_stall_lo got %b exp 0", stall0); end
        in_req = 1'b1; #1;
        checks++; if (stall0 !== 1'b1 || stall1 !== 1'b1) begin failures++; $display("FAIL reset_stall_follow got %b/%b exp 1", stall0, stall1); end
        in_req = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int w0;
        w0 = wr_cnt;
        in_req = 1'b1; in_dest = 5'd7; fpga_in = 16'h1234; #1;
        checks++; if (stall0 !== 1'b1 || flag0 !== 1'b0) begin failures++; $display("FAIL basic_k stall=%b flag=%b exp 1/0", stall0, flag0); end
        step();
        in_req = 1'b0;
        checks++; if (flag0 !== 1'b1 || wait0 !== 1'b1 || stall0 !== 1'b1) begin failures++; $display("FAIL basic_k1 flag=%b wait=%b stall=%b exp 1/1/1", flag0, wait0, stall0); end
        for (int i = 0; i < 10; i++) step();
        checks++; if (flag0 !== 1'b1 || wr0 !== 1'b0 || stall0 !== 1'b1) begin failures++; $display("FAIL basic_wait flag=%b wr=%b stall=%b exp 1/0/1", flag0, wr0, stall0); end
        confirm = 1'b1;
        step();
        checks++; if (wr0 !== 1'b1 || flag0 !== 1'b0 || waddr0 !== 5'd7) begin failures++; $display("FAIL basic_wb wr=%b flag=%b addr=%0d exp 1/0/7", wr0, flag0, waddr0); end
        checks++; if (wdata0 !== 32'h0000_1234 || wdata1 !== 32'h0000_1234) begin failures++; $display("FAIL basic_data got %h/%h exp 00001234", wdata0, wdata1); end
        step();
        confirm = 1'b0; #1;
        checks++; if (wr0 !== 1'b0 || stall0 !== 1'b1) begin failures++; $display("FAIL basic_release wr=%b stall=%b exp 0/1", wr0, stall0); end
        step();
        checks++; if (stall0 !== 1'b0 || flag0 !== 1'b0) begin failures++; $display("FAIL basic_done stall=%b flag=%b exp 0/0", stall0, flag0); end
        step();
        checks++; if (stall0 !== 1'b0 || (wr_cnt - w0) !== 1) begin failures++; $display("FAIL basic_idle stall=%b writes=%0d exp 0/1", stall0, wr_cnt - w0); end
    endtask

    task automatic test_sign();
        in_req = 1'b1; in_dest = 5'd5; fpga_in = 16'h8001;
        step();
        in_req = 1'b0; confirm = 1'b1;
        step();
        checks++; if (wdata1 !== 32'hFFFF_8001) begin failures++; $display("FAIL sign_ext got %h exp ffff8001", wdata1); end
        checks++; if (wdata0 !== 32'h0000_8001) begin failures++; $display("FAIL zero_ext got %h exp 00008001", wdata0); end
        checks++; if (waddr1 !== 5'd5 || wr1 !== 1'b1) begin failures++; $display("FAIL sign_wr addr=%0d wr=%b exp 5/1", waddr1, wr1); end
        step();
        confirm = 1'b0;
        step(); step();
        checks++; if (stall1 !== 1'b0) begin failures++; $display("FAIL sign_idle stall=%b exp 0", stall1); end
    endtask

    task automatic test_back_to_back();
        int w0, r0;
        w0 = wr_cnt; r0 = rise_cnt;
        in_req = 1'b1; in_dest = 5'd3; fpga_in = 16'h00AA;
        step();
        confirm = 1'b1;
        step();
        checks++; if (waddr0 !== 5'd3 || wr0 !== 1'b1) begin failures++; $display("FAIL b2b_first addr=%0d wr=%b exp 3/1", waddr0, wr0); end
        step();
        confirm = 1'b0;
        step();
        in_dest = 5'd4; fpga_in = 16'h00BB; #1;
        checks++; if (stall0 !== 1'b0) begin failures++; $display("FAIL b2b_done stall=%b exp 0", stall0); end
        step();
        checks++; if (stall0 !== 1'b1 || flag0 !== 1'b0) begin failures++; $display("FAIL b2b_idle stall=%b flag=%b exp 1/0", stall0, flag0); end
        step();
        checks++; if (flag0 !== 1'b1) begin failures++; $display("FAIL b2b_flag2 got %b exp 1", flag0); end
        in_req = 1'b0; confirm = 1'b1;
        step();
        checks++; if (waddr0 !== 5'd4 || wdata0 !== 32'h0000_00BB) begin failures++; $display("FAIL b2b_second addr=%0d data=%h exp 4/000000bb", waddr0, wdata0); end
        step();
        confirm = 1'b0;
        step(); step();
        checks++; if ((wr_cnt - w0) !== 2 || (rise_cnt - r0) !== 2) begin failures++; $display("FAIL b2b_counts writes=%0d rises=%0d exp 2/2", wr_cnt - w0, rise_cnt - r0); end
    endtask

    task automatic test_confirm_hold();
        int w0;
        w0 = wr_cnt;
        in_req = 1'b1; in_dest = 5'd9; fpga_in = 16'h0042;
        step();
        in_req = 1'b0; confirm = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (stall0 !== 1'b1 || wr0 !== 1'b0 || flag0 !== 1'b0) begin failures++; $display("FAIL hold_release[%0d] stall=%b wr=%b flag=%b exp 1/0/0", i, stall0, wr0, flag0); end
        end
        confirm = 1'b0;
        step();
        checks++; if (stall0 !== 1'b0) begin failures++; $display("FAIL hold_done stall=%b exp 0", stall0); end
        step();
        checks++; if ((wr_cnt - w0) !== 1) begin failures++; $display("FAIL hold_writes got %0d exp 1", wr_cnt - w0); end
    endtask

    task automatic test_reset_mid();
        int w0;
        w0 = wr_cnt;
        in_req = 1'b1; in_dest = 5'd12; fpga_in = 16'h7777;
        step(); step();
        #2 rst_n = 1'b0; #1;
        checks++; if (flag0 !== 1'b0 || wait0 !== 1'b0 || waddr0 !== 5'd0 || wdata0 !== 32'h0 || wr0 !== 1'b0) begin failures++; $display("FAIL rstmid_outs flag=%b wait=%b addr=%0d data=%h wr=%b exp 0", flag0, wait0, waddr0, wdata0, wr0); end
        checks++; if (stall0 !== 1'b1) begin failures++; $display("FAIL rstmid_stall got %b exp 1", stall0); end
        confirm = 1'b1;
        step(); step();
        checks++; if ((wr_cnt - w0) !== 0 || flag0 !== 1'b0) begin failures++; $display("FAIL rstmid_nowrite writes=%0d flag=%b exp 0/0", wr_cnt - w0, flag0); end
        confirm = 1'b0;
        #3 rst_n = 1'b1;
        step();
        checks++; if (flag0 !== 1'b1) begin failures++; $display("FAIL rstmid_restart flag=%b exp 1", flag0); end
        in_req = 1'b0; confirm = 1'b1;
        step();
        checks++; if (wr0 !== 1'b1 || waddr0 !== 5'd12 || wdata0 !== 32'h0000_7777) begin failures++; $display("FAIL rstmid_complete wr=%b addr=%0d data=%h exp 1/12/00007777", wr0, waddr0, wdata0); end
        step();
        confirm = 1'b0;
        step(); step();
    endtask

    task automatic test_drop_req();
        int w0;
        w0 = wr_cnt;
        in_req = 1'b1; in_dest = 5'd20; fpga_in = 16'hC0DE;
        step();
        in_req = 1'b0;
        step(); step(); step();
        checks++; if (flag0 !== 1'b1 || stall0 !== 1'b1) begin failures++; $display("FAIL drop_wait flag=%b stall=%b exp 1/1", flag0, stall0); end
        confirm = 1'b1;
        step();
        checks++; if (wr0 !== 1'b1 || waddr0 !== 5'd20 || wdata1 !== 32'hFFFF_C0DE) begin failures++; $display("FAIL drop_write wr=%b addr=%0d data=%h exp 1/20/ffffc0de", wr0, waddr0, wdata1); end
        step();
        confirm = 1'b0;
        step(); step(); step();
        checks++; if ((wr_cnt - w0) !== 1 || stall0 !== 1'b0) begin failures++; $display("FAIL drop_writes writes=%0d stall=%b exp 1/0", wr_cnt - w0, stall0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign();
        test_back_to_back();
        test_confirm_hold();
        test_reset_mid();
        test_drop_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
